step_profile_generator: RTL and testbench

//  Downstream consumer of the max-timing selector. Latches the winning axis

---
 rtl/step_profile_generator.sv | 158 +++++++++++++++
 tb/tb_step_profile_generator.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/step_profile_generator.sv
// Trapezoid step playback: latches params/timing on start, then integrates speed into step pulses.
// Latency: start to first run tick is 1 cycle, and step is registered one cycle after the carry.
// Backpressure: none; finish is held until start drops. Optional abort is enabled by STEP_PROFILE_ABORT_EN.
module step_profile_generator #(
    parameter int ACC_W  = 32,
    parameter int TICK_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ACC_W-1:0]  max_params [0:4],
    input  logic [TICK_W-1:0] max_timing [0:3],
`ifdef STEP_PROFILE_ABORT_EN
    input  logic              abort,
    output logic              aborted,
`endif
    output logic              step,
    output logic              dir,
    output logic              busy,
    output logic              finish,
    output logic [ACC_W-1:0]  steps_done,
    output logic [2:0]        phase
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCEL  = 3'd1,
        S_CRUISE = 3'd2,
        S_DECEL  = 3'd3,
        S_TAIL   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t state, state_nxt, run_ph;

    logic [ACC_W-1:0]  p_total, p_vstart, p_vcruise, p_accel;
    logic [TICK_W-1:0] t0, t1, t2, t3, t;
    logic [ACC_W-1:0]  speed, acc, speed_nxt, spd_dn;
    logic [ACC_W:0]    acc_sum, spd_up;
    logic              fin_run, abort_hit, stop_run;
    logic              unused_bits;

    assign unused_bits = &{1'b0, max_params[4][ACC_W-1:1]};

`ifdef STEP_PROFILE_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    assign fin_run  = (steps_done == p_total) || (t >= t3);
    assign stop_run = fin_run || abort_hit;
    assign acc_sum  = {1'b0, acc} + {1'b0, speed};
    assign spd_up   = {1'b0, speed} + {1'b0, p_accel};
    assign spd_dn   = speed - p_accel;

    // Zero-length phases collapse through the chain in a single tick.
    always_comb begin
        run_ph = state;
        if (run_ph == S_ACCEL  && t >= t0) run_ph = S_CRUISE;
        if (run_ph == S_CRUISE && t >= t1) run_ph = S_DECEL;
        if (run_ph == S_DECEL  && t >= t2) run_ph = S_TAIL;
    end

    always_comb begin
        speed_nxt = speed;
        case (run_ph)
            S_ACCEL: speed_nxt = (spd_up > {1'b0, p_vcruise}) ? p_vcruise : spd_up[ACC_W-1:0];
            S_DECEL: speed_nxt = (speed < p_accel || spd_dn < p_vstart) ? p_vstart : spd_dn;
            default: speed_nxt = speed;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = (max_params[0] == '0) ? S_DONE : S_ACCEL;
            S_ACCEL, S_CRUISE, S_DECEL, S_TAIL:
                     state_nxt = stop_run ? S_DONE : run_ph;
            S_DONE:  if (!start) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy   = (state == S_ACCEL) || (state == S_CRUISE) || (state == S_DECEL) || (state == S_TAIL);
        finish = (state == S_DONE);
        phase  = state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            p_total    <= '0;
            p_vstart   <= '0;
            p_vcruise  <= '0;
            p_accel    <= '0;
            t0         <= '0;
            t1         <= '0;
            t2         <= '0;
            t3         <= '0;
            t          <= '0;
            speed      <= '0;
            acc        <= '0;
            steps_done <= '0;
            step       <= 1'b0;
            dir        <= 1'b0;
        end else begin
            step <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        p_total    <= max_params[0];
                        p_vstart   <= max_params[1];
                        p_vcruise  <= max_params[2];
                        p_accel    <= max_params[3];
                        dir        <= max_params[4][0];
                        t0         <= max_timing[0];
                        t1         <= max_timing[1];
                        t2         <= max_timing[2];
                        t3         <= max_timing[3];
                        speed      <= max_params[1];
                        acc        <= '0;
                        t          <= '0;
                        steps_done <= '0;
                    end
                end
                S_DONE: begin
                    if (!start) steps_done <= '0;
                end
                default: begin
                    if (!stop_run) begin
                        acc   <= acc_sum[ACC_W-1:0];
                        t     <= t + 1'b1;
                        speed <= speed_nxt;
                        if (acc_sum[ACC_W] && steps_done < p_total) begin
                            step       <= 1'b1;
                            steps_done <= steps_done + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

`ifdef STEP_PROFILE_ABORT_EN
    always_ff @(posedge clk) begin
        if (reset)                               aborted <= 1'b0;
        else if (busy && abort)                  aborted <= 1'b1;
        else if (state == S_DONE && !start)      aborted <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_step_profile_generator.sv
// Directed bench for step_profile_generator: hand-computed step timing, phase chain, timeout, reset, abort.
module tb_step_profile_generator;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [31:0] mp [0:4];
    logic [63:0] mt [0:3];
    logic        step, dir, busy, finish;
    logic [31:0] steps_done;
    logic [2:0]  phase;
`ifdef STEP_PROFILE_ABORT_EN
    logic        abort, aborted;
`endif

    int total = 0;
    int bad   = 0;
    logic busy_seen, step_seen;

    always #5 clk = ~clk;

    step_profile_generator #(.ACC_W(32), .TICK_W(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .max_params (mp),
        .max_timing (mt),
`ifdef STEP_PROFILE_ABORT_EN
        .abort      (abort),
        .aborted    (aborted),
`endif
        .step       (step),
        .dir        (dir),
        .busy       (busy),
        .finish     (finish),
        .steps_done (steps_done),
        .phase      (phase)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic set_t1();
        mp[0] = 32'd4; mp[1] = 32'h4000_0000; mp[2] = 32'h4000_0000; mp[3] = 32'd0; mp[4] = 32'd0;
        mt[0] = 64'd0; mt[1] = 64'd100; mt[2] = 64'd100; mt[3] = 64'd100;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
`ifdef STEP_PROFILE_ABORT_EN
        abort = 1'b0;
`endif
        for (int i = 0; i < 5; i++) mp[i] = '0;
        for (int i = 0; i < 4; i++) mt[i] = '0;
        tick();
        tick();
        chk("rst_phase", phase, 0);
        chk("rst_busy", busy, 0);
        chk("rst_finish", finish, 0);
        chk("rst_step", step, 0);
        chk("rst_steps", steps_done, 0);
        chk("rst_dir", dir, 0);
        reset = 1'b0;
        tick();

        // Test 1: quarter-step speed, four steps
        set_t1();
        start = 1'b1;
        tick();
        chk("t1_latch_phase", phase, 1);
        chk("t1_latch_busy", busy, 1);
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk("t1_step", step, (k % 4 == 0));
            if (k == 1) chk("t1_skip_accel", phase, 2);
        end
        chk("t1_steps4", steps_done, 4);
        tick();
        chk("t1_finish", finish, 1);
        chk("t1_done_step", step, 0);
        chk("t1_done_busy", busy, 0);
        chk("t1_done_phase", phase, 5);
        chk("t1_done_steps", steps_done, 4);
        chk("t1_dir", dir, 0);
        tick();
        chk("t1_finish_held", finish, 1);
        start = 1'b0;
        tick();
        chk("t1_idle_phase", phase, 0);
        chk("t1_idle_finish", finish, 0);
        chk("t1_idle_steps", steps_done, 0);

        // Test 2: zero-step move
        mp[0] = 32'd0;
        start = 1'b1;
        busy_seen = 1'b0;
        step_seen = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            busy_seen = busy_seen | busy;
            step_seen = step_seen | step;
        end
        chk("t2_finish", finish, 1);
        chk("t2_phase", phase, 5);
        chk("t2_no_busy", busy_seen, 0);
        chk("t2_no_step", step_seen, 0);
        start = 1'b0;
        tick();
        chk("t2_idle", phase, 0);

        // Test 3: full trapezoid, speed clamps at 0.5 after 8 accel ticks
        mp[0] = 32'd1000; mp[1] = 32'd0; mp[2] = 32'h8000_0000; mp[3] = 32'h1000_0000; mp[4] = 32'd1;
        mt[0] = 64'd20; mt[1] = 64'd40; mt[2] = 64'd60; mt[3] = 64'd1000;
        start = 1'b1;
        tick();
        mp[0] = 32'd1;
        mt[3] = 64'd2;
        chk("t3_dir", dir, 1);
        chk("t3_phase_accel", phase, 1);
        for (int k = 1; k <= 61; k++) begin
            tick();
            if (k == 20) begin
                chk("t3_ph20", phase, 1);
                chk("t3_steps20", steps_done, 7);
            end
            if (k == 21) chk("t3_ph21", phase, 2);
            if (k == 40) begin
                chk("t3_ph40", phase, 2);
                chk("t3_steps40", steps_done, 17);
            end
            if (k == 41) chk("t3_ph41", phase, 3);
            if (k == 60) chk("t3_ph60", phase, 3);
            if (k == 61) begin
                chk("t3_ph61", phase, 4);
                chk("t3_steps61", steps_done, 20);
            end
        end
        start = 1'b0;
        reset = 1'b1;
        tick();
        chk("t3_rst_phase", phase, 0);
        chk("t3_rst_busy", busy, 0);
        chk("t3_rst_dir", dir, 0);
        chk("t3_rst_steps", steps_done, 0);
        reset = 1'b0;
        tick();
        chk("t3_stay_idle", phase, 0);

        // Test 4: timeout at T3 with steps outstanding
        mp[0] = 32'd1000; mp[1] = 32'h1000_0000; mp[2] = 32'h1000_0000; mp[3] = 32'd0; mp[4] = 32'd0;
        mt[0] = 64'd0; mt[1] = 64'd0; mt[2] = 64'd0; mt[3] = 64'd50;
        start = 1'b1;
        tick();
        for (int k = 1; k <= 50; k++) begin
            tick();
            if (k == 1) chk("t4_chain_tail", phase, 4);
        end
        chk("t4_pre_finish", finish, 0);
        chk("t4_pre_steps", steps_done, 3);
        tick();
        chk("t4_finish", finish, 1);
        chk("t4_steps", steps_done, 3);
        chk("t4_phase", phase, 5);
        start = 1'b0;
        tick();
        chk("t4_idle_phase", phase, 0);
        chk("t4_idle_steps", steps_done, 0);

        // Test 5: reset mid-move, start held relaunches
        set_t1();
        start = 1'b1;
        tick();
        for (int k = 1; k <= 10; k++) tick();
        chk("t5_steps10", steps_done, 2);
        reset = 1'b1;
        tick();
        chk("t5_rst_step", step, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_finish", finish, 0);
        chk("t5_rst_phase", phase, 0);
        chk("t5_rst_steps", steps_done, 0);
        reset = 1'b0;
        tick();
        chk("t5_relaunch", phase, 1);
        for (int k = 1; k <= 16; k++) tick();
        chk("t5_steps16", steps_done, 4);
        chk("t5_step16", step, 1);
        tick();
        chk("t5_finish", finish, 1);
        start = 1'b0;
        tick();
        chk("t5_idle", phase, 0);

`ifdef STEP_PROFILE_ABORT_EN
        // Test 6: abort freezes the move
        set_t1();
        start = 1'b1;
        tick();
        for (int k = 1; k <= 5; k++) tick();
        abort = 1'b1;
        tick();
        chk("t6_finish", finish, 1);
        chk("t6_aborted", aborted, 1);
        chk("t6_steps", steps_done, 1);
        chk("t6_step", step, 0);
        chk("t6_phase", phase, 5);
        abort = 1'b0;
        step_seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            step_seen = step_seen | step;
        end
        chk("t6_no_step", step_seen, 0);
        chk("t6_steps_frozen", steps_done, 1);
        start = 1'b0;
        tick();
        chk("t6_aborted_clr", aborted, 0);
        chk("t6_idle", phase, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
